if_stage: RTL and testbench
===========================

# if_stage

Instruction fetch stage for the five-stage RV32I core. Holds the program counter, reads a synchronous instruction memory, and presents `instr`/`pc` to the decode stage through a registered IF/ID boundary. Accepts stall from the hazard unit and a taken-branch/jump redirect from execute, and provides a write port so benches and the boot loader can fill instruction memory.

## Interface
- `WORD_SIZE`, 32, instruction and PC width
- `ADDR_SIZE`, 10, instruction memory word-address width (2^ADDR_SIZE words)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hold PC and IF/ID outputs
- `redirect`  in  1  taken branch/jump this cycle
- `redirect_pc`  in  WORD_SIZE  target address for redirect
- `imem_we`  in  1  instruction memory write enable
- `imem_waddr`  in  ADDR_SIZE  word address for write
- `imem_wdata`  in  WORD_SIZE  write data
- `instr`  out  WORD_SIZE  instruction to decode (registered)
- `pc`  out  WORD_SIZE  address of `instr` (registered)
- `pc_plus4`  out  WORD_SIZE  `pc + 4`, for JAL/JALR link
- `valid`  out  1  `instr` is a real fetched instruction, not a bubble

## Operation
- Internal fetch pointer `fetch_pc`; memory index = `fetch_pc[ADDR_SIZE+1:2]`, upper bits ignored (index wraps modulo 2^ADDR_SIZE).
- Priority per edge: `rst` > `redirect` > `stall` > normal.
- Reset: `fetch_pc`=RESET_PC; `instr`=`INSTR_NOP` (32'h0000_0013); `pc`=0; `pc_plus4`=4; `valid`=0. Reset mid-stream discards the in-flight instruction; no partial state survives.
- Normal: IF/ID captures `mem[fetch_pc]`, `pc`<=`fetch_pc`, `valid`<=1; `fetch_pc`<=`fetch_pc+4` (mod 2^WORD_SIZE).
- Stall: `fetch_pc`, `instr`, `pc`, `valid` all hold; memory read address held so `instr` is unchanged.
- Redirect: `fetch_pc`<=`{redirect_pc[WORD_SIZE-1:2],2'b00}` (misaligned low bits cleared); IF/ID loads bubble (`instr`=NOP, `valid`=0, `pc` holds). Redirect during stall still takes effect.
- Memory write: on edge with `imem_we`, `mem[imem_waddr]`<=`imem_wdata`. Write and fetch to same index on same edge: fetch returns old data (read-first).
- Memory contents undefined until written; bench always loads before releasing reset.

## Timing
- Fetch latency: 1 cycle from `fetch_pc` to `instr` valid.
- First `valid`=1 at the first rising edge with `rst`=0, `pc`=RESET_PC.
- Redirect penalty: 1 bubble; target instruction valid on the second edge after `redirect` sampled.
- Stall is level-sensitive; outputs release on the first edge with `stall`=0.
- `pc_plus4` is combinational from registered `pc`.

## Configuration
- `IF_PERF_CNT_EN` defined: adds output `fetch_count` (32 bits), reset to 0, increments on each edge that loads a valid instruction into IF/ID; holds on stall, redirect bubble, and reset-held cycles; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- `defines.vh` gains `INSTR_NOP` and `RESET_PC_DEFAULT`; no new typedefs.
- One sub-module `instr_mem`: 2^ADDR_SIZE x WORD_SIZE, one synchronous read port with read-enable (deasserted on stall), one synchronous write port, read-first. PC and IF/ID logic stay in `if_stage`.

## Test plan
- Load mem[0..2]=00c00713, 00ee8c33, 200c2803; release reset -> edges 1..3 give `instr`=those words, `pc`=0,4,8, `valid`=1.
- Assert `stall` for 3 cycles after `pc`=4 -> `instr`=00ee8c33, `pc`=4 held; next edge `pc`=8.
- `redirect`=1, `redirect_pc`=0x130 while `pc`=4 -> next edge `valid`=0, `instr`=00000013; following edge `pc`=0x130, `instr`=mem[76].
- `redirect_pc`=0x0000_0FFE (ADDR_SIZE=10) -> fetch at 0xFFC, index 1023; next sequential `pc`=0x1000 reads index 0 (wrap).
- `imem_we` to index 2 with 12fc5863 on same edge fetch reads index 2 -> `instr`=old 200c2803; later fetch of index 2 returns 12fc5863.
- With `IF_PERF_CNT_EN`: 5 normal fetches, 2 stalls, 1 redirect -> `fetch_count`=5 before redirect target arrives, 6 after; `rst` mid-run -> 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants for the instruction fetch stage
// Optional fetch counter is enabled by defining IF_PERF_CNT_EN.
package if_stage_pkg;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - control, imem write and IF/ID output bundle of the fetch stage
// fetch_count exists only when IF_PERF_CNT_EN is defined.
interface if_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
);
  logic                 stall;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 imem_we;
  logic [ADDR_SIZE-1:0] imem_waddr;
  logic [WORD_SIZE-1:0] imem_wdata;
  logic [WORD_SIZE-1:0] instr;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_plus4;
  logic                 valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]          fetch_count;
`endif

  modport master (
    output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
`ifdef IF_PERF_CNT_EN
    input  fetch_count,
`endif
    input  instr, pc, pc_plus4, valid
  );

  modport slave (
    input  stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
`ifdef IF_PERF_CNT_EN
    output fetch_count,
`endif
    output instr, pc, pc_plus4, valid
  );
endinterface

// File: rtl/if_stage_instr_mem.sv
// rtl/if_stage_instr_mem.sv - synchronous instruction memory, read-first, one read and one write port
module instr_mem #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [WORD_SIZE-1:0] rdata_o,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [WORD_SIZE-1:0] wdata_i
);
  logic [WORD_SIZE-1:0] mem_q [2**ADDR_SIZE];
  logic [WORD_SIZE-1:0] rdata_q;

  // Both updates are non-blocking, so a same-index read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I fetch stage: PC, instruction memory and IF/ID boundary
// Defining IF_PERF_CNT_EN adds the fetch_count output.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_SIZE = 10,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEFAULT)
) (
  input logic      clk_i,
  input logic      rst_i,
  if_stage_if.slave bus
);
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 load_en;

  assign load_en = !bus.redirect && !bus.stall;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & ~WORD_SIZE'(3);
      valid_d    = 1'b0;
    end else if (!bus.stall) begin
      fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
      pc_d       = fetch_pc_q;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  instr_mem #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_instr_mem (
    .clk_i  (clk_i),
    .re_i   (!bus.stall),
    .raddr_i(fetch_pc_q[ADDR_SIZE+1:2]),
    .rdata_o(mem_rdata),
    .we_i   (bus.imem_we),
    .waddr_i(bus.imem_waddr),
    .wdata_i(bus.imem_wdata)
  );

  // The memory output register is the IF/ID instruction; bubbles are masked to NOP.
  assign bus.instr    = valid_q ? mem_rdata : WORD_SIZE'(INSTR_NOP);
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + WORD_SIZE'(4);
  assign bus.valid    = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)        fetch_count_q <= '0;
    else if (load_en) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign bus.fetch_count = fetch_count_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage (covers IF_PERF_CNT_EN when defined)
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // load=1 when this edge should move a real instruction into IF/ID
  task automatic step(input bit load);
    @(posedge clk);
    #1;
    if (load) exp_cnt++;
  endtask

  task automatic check_cnt(input string tag);
`ifdef IF_PERF_CNT_EN
    check(tag, bus.fetch_count, 32'(exp_cnt));
`else
    if (tag.len() == 0) $display("unnamed count point");
`endif
  endtask

  task automatic write_mem(input logic [9:0] a, input logic [31:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = d;
    step(1'b0);
    bus.imem_we    = 1'b0;
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_we     = 1'b0;
    bus.imem_waddr  = '0;
    bus.imem_wdata  = '0;

    write_mem(10'd0,    32'h00c00713);
    write_mem(10'd1,    32'h00ee8c33);
    write_mem(10'd2,    32'h200c2803);
    write_mem(10'd76,   32'h00100093);
    write_mem(10'd1023, 32'h00200113);

    check("rst_instr", bus.instr, 32'h00000013);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pc4", bus.pc_plus4, 32'h4);
    check("rst_valid", {31'b0, bus.valid}, 32'h0);
    check_cnt("rst_cnt");

    rst = 1'b0;
    step(1'b1);
    check("f0_instr", bus.instr, 32'h00c00713);
    check("f0_pc", bus.pc, 32'h0);
    check("f0_valid", {31'b0, bus.valid}, 32'h1);
    step(1'b1);
    check("f1_instr", bus.instr, 32'h00ee8c33);
    check("f1_pc4", bus.pc_plus4, 32'h8);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("stall_instr", bus.instr, 32'h00ee8c33);
      check("stall_pc", bus.pc, 32'h4);
      check("stall_valid", {31'b0, bus.valid}, 32'h1);
    end
    check_cnt("stall_cnt");
    bus.stall = 1'b0;
    step(1'b1);
    check("rel_instr", bus.instr, 32'h200c2803);
    check("rel_pc", bus.pc, 32'h8);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h4;
    step(1'b0);
    bus.redirect = 1'b0;
    step(1'b1);
    check("back4_pc", bus.pc, 32'h4);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h132;
    step(1'b0);
    bus.redirect = 1'b0;
    check("bub_valid", {31'b0, bus.valid}, 32'h0);
    check("bub_instr", bus.instr, 32'h00000013);
    check("bub_pc", bus.pc, 32'h4);
    check_cnt("bub_cnt");
    step(1'b1);
    check("tgt_pc", bus.pc, 32'h130);
    check("tgt_instr", bus.instr, 32'h00100093);
    check_cnt("tgt_cnt");

    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0FFE;
    step(1'b0);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    check("sr_valid", {31'b0, bus.valid}, 32'h0);
    check("sr_pc", bus.pc, 32'h130);
    step(1'b1);
    check("top_pc", bus.pc, 32'h0FFC);
    check("top_instr", bus.instr, 32'h00200113);
    step(1'b1);
    check("wrap_pc", bus.pc, 32'h1000);
    check("wrap_instr", bus.instr, 32'h00c00713);
    step(1'b1);
    check("w1_instr", bus.instr, 32'h00ee8c33);

    bus.imem_we = 1'b1;
    bus.imem_waddr = 10'd2;
    bus.imem_wdata = 32'h12fc5863;
    step(1'b1);
    bus.imem_we = 1'b0;
    check("rf_instr", bus.instr, 32'h200c2803);
    check("rf_pc", bus.pc, 32'h1008);

    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h8;
    step(1'b0);
    bus.redirect = 1'b0;
    step(1'b1);
    check("new_instr", bus.instr, 32'h12fc5863);
    check_cnt("run_cnt");

    rst = 1'b1;
    exp_cnt = 0;
    step(1'b0);
    step(1'b0);
    check("mrst_valid", {31'b0, bus.valid}, 32'h0);
    check("mrst_instr", bus.instr, 32'h00000013);
    check("mrst_pc", bus.pc, 32'h0);
    check_cnt("mrst_cnt");
    rst = 1'b0;
    step(1'b1);
    check("post_instr", bus.instr, 32'h00c00713);
    check("post_valid", {31'b0, bus.valid}, 32'h1);
    check_cnt("post_cnt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
